// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   READ/WRITE   : memory transfer direction encodings
//   ENABLE/DISABLE : strobe levels
//   owner_t      : which requester owns the in-flight access
package memory_port_arbiter_pkg;

    localparam logic READ    = 1'b0;
    localparam logic WRITE   = 1'b1;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [3:0] FULL_WORD_MASK = 4'b1111;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/memory_port_arbiter_select.sv
// Grant decision for the shared memory port plus the data-streak counter
// that bounds instruction-fetch starvation.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   instr_req, data_req   : raw request levels from the two interfaces
//   idle                  : arbiter FSM is in IDLE (grants only happen here)
//   grant_instr, grant_data : one-hot grant for this cycle (combinational)
module memory_port_arbiter_select
    import memory_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic instr_req,
    input  logic data_req,
    input  logic idle,
    output logic grant_instr,
    output logic grant_data
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak;
    logic          streak_full;

    assign streak_full = (streak == STREAK_MAX);

    // Data wins unless a fetch is pending and has already waited out a full streak.
    assign grant_data  = idle && data_req && !(instr_req && streak_full);
    assign grant_instr = idle && instr_req && (!data_req || streak_full);

    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (grant_instr) begin
            streak <= '0;
        end else if (grant_data) begin
            if (!instr_req) begin
                streak <= '0;
            end else if (!streak_full) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates the instruction and data memory interfaces onto one
// single-ported unified memory. Every access is registered toward memory,
// held until mem_ready (or a watchdog timeout), then acknowledged to its
// owner with a one-cycle ready pulse.
//
//   state | meaning
//   IDLE  | sample requests, latch the granted access, raise mem_enable
//   BUSY  | mem_enable held, waiting for mem_ready or watchdog expiry
//   RESP  | owner ready (and bus_error if aborted) pulse for one cycle
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   instr_enable/address           : fetch request; instr_rdata/ready response
//   data_enable/state/address/
//   frame_mask/wdata               : load/store request; data_rdata/ready response
//   bus_error                      : pulses with ready of a timed-out access
//   mem_enable/state/address/
//   frame_mask/wdata               : registered access toward memory
//   mem_rdata, mem_ready           : memory response
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_rdata,
    output logic        instr_ready,
    input  logic        data_enable,
    input  logic        data_state,
    input  logic [31:0] data_address,
    input  logic [3:0]  data_frame_mask,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        bus_error,
    output logic        mem_enable,
    output logic        mem_state,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_frame_mask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    owner_t        owner;
    logic [TW-1:0] timer;
    logic          grant_instr;
    logic          grant_data;

    memory_port_arbiter_select #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_select (
        .clk         (clk),
        .reset       (reset),
        .instr_req   (instr_enable),
        .data_req    (data_enable),
        .idle        (state == ST_IDLE),
        .grant_instr (grant_instr),
        .grant_data  (grant_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            owner          <= OWNER_INSTR;
            timer          <= '0;
            instr_rdata    <= '0;
            instr_ready    <= 1'b0;
            data_rdata     <= '0;
            data_ready     <= 1'b0;
            bus_error      <= 1'b0;
            mem_enable     <= DISABLE;
            mem_state      <= READ;
            mem_address    <= '0;
            mem_frame_mask <= '0;
            mem_wdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_data) begin
                        owner          <= OWNER_DATA;
                        mem_enable     <= ENABLE;
                        mem_state      <= data_state;
                        mem_address    <= data_address;
                        mem_frame_mask <= data_frame_mask;
                        mem_wdata      <= data_wdata;
                        timer          <= TIMER_LOAD;
                        state          <= ST_BUSY;
                    end else if (grant_instr) begin
                        owner          <= OWNER_INSTR;
                        mem_enable     <= ENABLE;
                        mem_state      <= READ;
                        mem_address    <= instr_address;
                        mem_frame_mask <= FULL_WORD_MASK;
                        mem_wdata      <= '0;
                        timer          <= TIMER_LOAD;
                        state          <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // mem_ready wins over an expiring watchdog in the same cycle.
                    if (mem_ready) begin
                        mem_enable <= DISABLE;
                        if (owner == OWNER_INSTR) begin
                            instr_ready <= 1'b1;
                            instr_rdata <= (mem_state == READ) ? mem_rdata : 32'h0;
                        end else begin
                            data_ready  <= 1'b1;
                            data_rdata  <= (mem_state == READ) ? mem_rdata : 32'h0;
                        end
                        state <= ST_RESP;
                    end else if (timer == '0) begin
                        mem_enable <= DISABLE;
                        bus_error  <= 1'b1;
                        if (owner == OWNER_INSTR) begin
                            instr_ready <= 1'b1;
                            instr_rdata <= 32'h0;
                        end else begin
                            data_ready  <= 1'b1;
                            data_rdata  <= 32'h0;
                        end
                        state <= ST_RESP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_RESP: begin
                    instr_ready <= 1'b0;
                    data_ready  <= 1'b0;
                    bus_error   <= 1'b0;
                    instr_rdata <= '0;
                    data_rdata  <= '0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_enable = 1'b0;
    logic [31:0] instr_address = '0;
    logic [31:0] instr_rdata;
    logic        instr_ready;
    logic        data_enable = 1'b0;
    logic        data_state = READ;
    logic [31:0] data_address = '0;
    logic [3:0]  data_frame_mask = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        bus_error;
    logic        mem_enable;
    logic        mem_state;
    logic [31:0] mem_address;
    logic [3:0]  mem_frame_mask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'hA5A5_A5A5;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    memory_port_arbiter #(
        .MAX_DATA_STREAK (4),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_enable    (instr_enable),
        .instr_address   (instr_address),
        .instr_rdata     (instr_rdata),
        .instr_ready     (instr_ready),
        .data_enable     (data_enable),
        .data_state      (data_state),
        .data_address    (data_address),
        .data_frame_mask (data_frame_mask),
        .data_wdata      (data_wdata),
        .data_rdata      (data_rdata),
        .data_ready      (data_ready),
        .bus_error       (bus_error),
        .mem_enable      (mem_enable),
        .mem_state       (mem_state),
        .mem_address     (mem_address),
        .mem_frame_mask  (mem_frame_mask),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    int   mem_wait  = 1;   // cycles of mem_enable before mem_ready (1 = zero-wait)
    bit   mem_hang  = 1'b0;
    bit   use_fixed = 1'b0;
    logic [31:0] fixed_val = '0;
    int   mcnt = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (mem_enable && !mem_hang) begin
            mcnt++;
            mem_ready = (mcnt == mem_wait);
        end else begin
            mcnt = 0;
            mem_ready = 1'b0;
        end
        mem_rdata = mem_ready ? (use_fixed ? fixed_val : mem_fn(mem_address)) : 32'hA5A5_A5A5;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_instr;
        logic [31:0] rdata;
        bit          err;
    } resp_t;

    resp_t exp_q[$];

    always @(negedge clk) begin
        resp_t e;
        if (instr_ready || data_ready) begin
            check32("single_ready", {31'b0, instr_ready & data_ready}, 32'h0);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ready: instr_ready=%0b data_ready=%0b with nothing expected (cycle %0d)",
                         instr_ready, data_ready, cyc);
            end else begin
                e = exp_q.pop_front();
                check32("resp_owner_instr", {31'b0, instr_ready}, {31'b0, e.is_instr});
                check32("resp_rdata", e.is_instr ? instr_rdata : data_rdata, e.rdata);
                check32("resp_bus_error", {31'b0, bus_error}, {31'b0, e.err});
            end
        end else if (bus_error) begin
            checks++;
            fails++;
            $display("FAIL stray_bus_error: bus_error=1 without ready (cycle %0d)", cyc);
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(instr_ready || data_ready) && n < bound);
        if (!(instr_ready || data_ready)) begin
            checks++;
            fails++;
            $display("FAIL ready_timeout: no ready within %0d cycles, required one", bound);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_instr_rdata"}, instr_rdata, 32'h0);
        check32({tag, "_data_rdata"}, data_rdata, 32'h0);
        check32({tag, "_mem_address"}, mem_address, 32'h0);
        check32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check32({tag, "_ctl_bits"},
                {24'b0, instr_ready, data_ready, bus_error, mem_enable, mem_state, 3'b0},
                32'h0);
        check32({tag, "_mem_mask"}, {28'b0, mem_frame_mask}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int got;
        int guard;
        int hi;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Fetch only, memory answers on the second enable cycle
        mem_wait = 2; use_fixed = 1'b1; fixed_val = 32'h0010_0093;
        instr_address = 32'h0000_0040; instr_enable = 1'b1;
        exp_q.push_back('{1'b1, 32'h0010_0093, 1'b0});
        c0 = cyc;
        @(negedge clk);
        check32("fetch_mem_enable", {31'b0, mem_enable}, 32'h1);
        check32("fetch_mem_mask", {28'b0, mem_frame_mask}, 32'hF);
        check32("fetch_mem_state", {31'b0, mem_state}, {31'b0, READ});
        check32("fetch_mem_address", mem_address, 32'h0000_0040);
        wait_ready(20);
        check32("fetch_latency", cyc - c0, 3);
        check32("fetch_mem_enable_dropped", {31'b0, mem_enable}, 32'h0);
        instr_enable = 1'b0;
        use_fixed = 1'b0;
        @(negedge clk);

        // Store to the printf sink, zero-wait memory
        mem_wait = 1;
        data_state = WRITE; data_address = 32'h1000_0000;
        data_frame_mask = 4'b0011; data_wdata = 32'hDEAD_BEEF; data_enable = 1'b1;
        exp_q.push_back('{1'b0, 32'h0, 1'b0});
        c0 = cyc;
        @(negedge clk);
        check32("store_mem_state", {31'b0, mem_state}, {31'b0, WRITE});
        check32("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check32("store_mem_mask", {28'b0, mem_frame_mask}, 32'h3);
        check32("store_mem_address", mem_address, 32'h1000_0000);
        wait_ready(20);
        check32("store_latency", cyc - c0, 2);
        data_enable = 1'b0;
        @(negedge clk);

        // Load with three-cycle memory
        mem_wait = 3;
        data_state = READ; data_address = 32'h0000_1234;
        data_frame_mask = 4'b1111; data_wdata = 32'h0;
        data_enable = 1'b1;
        exp_q.push_back('{1'b0, 32'h1234_EDCB, 1'b0});
        c0 = cyc;
        wait_ready(20);
        check32("load_latency", cyc - c0, 4);
        data_enable = 1'b0;
        @(negedge clk);

        // Both requesters held: D,D,D,D,I,D,D,D,D,I
        mem_wait = 1;
        instr_address = 32'h0000_0200;
        data_state = READ; data_address = 32'h0000_0300; data_frame_mask = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, 32'h0300_FCFF, 1'b0});
            exp_q.push_back('{1'b1, 32'h0200_FDFF, 1'b0});
        end
        instr_enable = 1'b1; data_enable = 1'b1;
        got = 0; guard = 0;
        while (got < 10 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (instr_ready || data_ready) got++;
        end
        check32("streak_ready_count", got, 10);
        instr_enable = 1'b0; data_enable = 1'b0;
        @(negedge clk);

        // Hung memory: watchdog aborts after TO busy cycles
        mem_hang = 1'b1;
        data_state = READ; data_address = 32'h0000_0080; data_enable = 1'b1;
        exp_q.push_back('{1'b0, 32'h0, 1'b1});
        hi = 0; guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (mem_enable) hi++;
        end while ((mem_enable || hi == 0) && guard < 100);
        check32("timeout_busy_cycles", hi, TO);
        check32("timeout_ready_err", {30'b0, data_ready, bus_error}, 32'h3);
        data_enable = 1'b0;
        mem_hang = 1'b0;
        @(negedge clk);

        // Reset in the middle of a three-cycle access
        mem_wait = 3;
        data_state = READ; data_address = 32'h0000_0044; data_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check32("pre_reset_busy", {31'b0, mem_enable}, 32'h1);
        reset = 1'b1; data_enable = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check32("post_reset_idle", {31'b0, mem_enable}, 32'h0);
        mem_wait = 1;
        instr_address = 32'h0000_0088; instr_enable = 1'b1;
        exp_q.push_back('{1'b1, 32'h0088_FF77, 1'b0});
        c0 = cyc;
        wait_ready(20);
        check32("post_reset_fetch_latency", cyc - c0, 2);
        instr_enable = 1'b0;
        @(negedge clk);

        // data_enable withdrawn while the access is in flight
        mem_wait = 3;
        data_state = WRITE; data_address = 32'h0000_0010;
        data_frame_mask = 4'b1100; data_wdata = 32'h1234_5678; data_enable = 1'b1;
        exp_q.push_back('{1'b0, 32'h0, 1'b0});
        c0 = cyc;
        @(negedge clk);
        check32("drop_mem_enable", {31'b0, mem_enable}, 32'h1);
        data_enable = 1'b0;
        wait_ready(20);
        check32("drop_latency", cyc - c0, 4);
        repeat (4) @(negedge clk);
        check32("drop_idle", {31'b0, mem_enable}, 32'h0);

        repeat (2) @(negedge clk);
        check32("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
